display_arbiter: RTL
====================

Name: display_arbiter

Overview:
- Shares the single 4-digit seven-segment display (the hexs/points/LEs input of the display driver) among three requesters: 0 = alert, 1 and 2 = normal.
- Grants ownership with a minimum dwell time, round-robin rotation and preemption on a new alert.
- Registers the granted owner's digit data and drives it to the display driver.
- Sits between the game/timer logic and the display driver.

Parameters:
- HOLD_CYCLES, 100_000_000: minimum ownership length in clk cycles. Must be ≥ 1.
- BLINK_BIT, 24: free-running counter bit used as the blink phase. Used only with the optional feature.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; asynchronous, active-low.
- req  in  3  request per requester. Bit i belongs to requester i.
- hexs_in  in  48  digit nibbles. Requester i uses [16i+15:16i].
- points_in  in  12  decimal points. Requester i uses [4i+3:4i]. 1 = point off.
- LEs_in  in  12  digit blanks. Requester i uses [4i+3:4i]. 1 = digit blanked.
- blink  in  3  per-requester blink enable. Used only with the optional feature.
- hexs  out  16  registered nibbles to the display driver.
- points  out  4  registered points.
- LEs  out  4  registered blanks.
- grant  out  3  one-hot current owner. 0 = idle.
- busy  out  1  high when grant != 0.
- switch_pulse  out  1  one-cycle pulse in the cycle after the owner changes (idle → owner, or owner → different owner).

Behaviour:
- Reset (rst=0, asynchronous, any time including mid-ownership):
  - grant=0, busy=0, switch_pulse=0.
  - hexs=16'h0000, points=4'hF, LEs=4'hF.
  - dwell counter=0, rr_last=2, req0_d=0.
- States: IDLE and OWN(g), with g in {0,1,2}. All outputs are registered; there is 1 cycle of latency from a sampled req to grant and data.
- req0_rise = req[0] & ~req0_d. req0_d is a register of req[0].
- Winner search, used for rotation and from IDLE: check in order rr_last+1, rr_last+2, rr_last (mod 3). The first requester with req high wins.
- IDLE:
  - Any req high → OWN(winner). Load that requester's data, set grant, dwell=0, switch_pulse=1.
  - No req → stay in IDLE with blank outputs.
- OWN(g), data:
  - req[g] high → reload the output registers from requester g every cycle.
  - req[g] low → freeze the last loaded values.
- OWN(g), dwell counter:
  - Increments each cycle and saturates at HOLD_CYCLES-1.
  - hold_done = (dwell == HOLD_CYCLES-1).
  - Counter width is $clog2(HOLD_CYCLES) bits, minimum 1.
- OWN(g), transitions at each edge, highest priority first:
  1. req0_rise and g != 0 → OWN(0), dwell=0, switch_pulse=1. Preemption ignores hold_done.
  2. hold_done and some requester other than g is requesting → OWN(next).
     - next = first requester with req high among g+1, g+2 (mod 3).
     - rr_last=g, dwell=0, switch_pulse=1.
  3. hold_done and only req[g] is high → stay in OWN(g). Dwell stays saturated.
  4. hold_done and no req → IDLE. Blank the outputs, grant=0, rr_last=g.
  5. Otherwise → stay in OWN(g).
- An owner that drops req before hold_done keeps the display (frozen data) for the full HOLD_CYCLES.
- A level-held req[0] does not preempt repeatedly; after its dwell it rotates fairly like the other requesters.
- HOLD_CYCLES=1: rotation is possible at every edge.
- Simultaneous req0_rise and hold_done: rule 1 wins.

Optional Feature:
- Macro: DISPLAY_ARBITER_BLINK_EN.
- When defined:
  - A free-running counter of BLINK_BIT+1 bits runs from reset (reset value 0).
  - When blink[g] of the current owner is 1 and counter[BLINK_BIT]=1, LEs is forced to 4'hF. Registered; hexs and points are unaffected.
  - The counter is not used in IDLE.
- When undefined: no counter; the blink port is ignored; LEs is always the owner's LEs_in.

Test Plan:
- (HOLD_CYCLES=4, BLINK_BIT=2 for all scenarios.)
- Reset: assert rst=0 during OWN(1) → same cycle grant=0, busy=0, hexs=0000, points=F, LEs=F. After release with req=0 → outputs stay blank.
- Single request: req=3'b010, hexs_in[31:16]=16'h1234 sampled at edge k → at k+1 grant=010, hexs=1234, switch_pulse=1. Drop req at k+1 → grant held through cycle k+4, hexs frozen at 1234. At k+5 grant=0, LEs=F.
- Rotation: req=3'b110 held → grant sequence 010 for 4 cycles, 100 for 4 cycles, 010, ... with switch_pulse at each change.
- Preemption: OWN(2) at dwell=1, req[0] rises → next cycle grant=001, switch_pulse=1, hexs=requester 0 nibbles. req[0] and req[2] held → after 4 cycles grant=100.
- Frozen data: owner 1 drops req at dwell=1 while hexs_in[31:16] changes to BEEF → hexs is unchanged until the handoff.
- Blink (macro defined): owner 1, blink=3'b010, LEs_in[7:4]=4'h0 → LEs alternates 0/F every 4 cycles. With blink=0, LEs stays 0.

Source files
------------

// File: rtl/display_arbiter.sv
// display_arbiter: shares the single 4-digit seven-segment display among an
// alert requester (0) and two normal requesters (1, 2). Ownership has a
// minimum dwell time, rotates round-robin and is preempted by a new alert.
// The granted owner's digit data is registered toward the display driver.
// Optional feature macro: DISPLAY_ARBITER_BLINK_EN (per-owner blanking blink).
module display_arbiter #(
  parameter int HOLD_CYCLES = 100_000_000,
  parameter int BLINK_BIT   = 24
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  req,
  input  logic [47:0] hexs_in,
  input  logic [11:0] points_in,
  input  logic [11:0] LEs_in,
  input  logic [2:0]  blink,
  output logic [15:0] hexs,
  output logic [3:0]  points,
  output logic [3:0]  LEs,
  output logic [2:0]  grant,
  output logic        busy,
  output logic        switch_pulse
);

  localparam int DW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [DW-1:0] DWELL_MAX = DW'(HOLD_CYCLES - 1);

  typedef enum logic {
    S_IDLE,
    S_OWN
  } stateType;

  stateType       r_state;
  stateType       w_nextState;
  logic [1:0]     r_owner;
  logic [1:0]     w_nextOwner;
  logic [1:0]     r_rrLast;
  logic [1:0]     w_nextRrLast;
  logic [DW-1:0]  r_dwell;
  logic [DW-1:0]  w_nextDwell;
  logic           r_req0d;
  logic [2:0]     r_grant;
  logic           r_switch;
  logic           w_nextSwitch;
  logic           w_load;
  logic           w_blank;
  logic [15:0]    r_hexs;
  logic [3:0]     r_points;
  logic [3:0]     r_lesData;
  logic [15:0]    w_nextHexs;
  logic [3:0]     w_nextPoints;
  logic [3:0]     w_nextLesData;
  logic           w_req0Rise;
  logic           w_holdDone;
  logic           w_othersReq;
  logic [1:0]     w_idleWinner;
  logic [1:0]     w_rotWinner;

  // Advance an index modulo 3.
  function automatic logic [1:0] inc3(input logic [1:0] x);
    return (x == 2'd2) ? 2'd0 : x + 2'd1;
  endfunction

  // First requester with req high among base+1, base+2, base (mod 3).
  function automatic logic [1:0] pickFrom(input logic [1:0] base, input logic [2:0] r);
    logic [1:0] c1;
    logic [1:0] c2;
    c1 = inc3(base);
    c2 = inc3(c1);
    if (r[c1])
      return c1;
    else if (r[c2])
      return c2;
    else
      return base;
  endfunction

  function automatic logic [2:0] toOneHot(input logic [1:0] idx);
    return 3'b001 << idx;
  endfunction

  assign w_req0Rise   = req[0] & ~r_req0d;
  assign w_holdDone   = (r_dwell == DWELL_MAX);
  assign w_othersReq  = |(req & ~toOneHot(r_owner));
  assign w_idleWinner = pickFrom(r_rrLast, req);
  assign w_rotWinner  = pickFrom(r_owner, req);

  // Next-state logic: preemption beats rotation, which beats staying or idling.
  always_comb begin
    w_nextState  = r_state;
    w_nextOwner  = r_owner;
    w_nextRrLast = r_rrLast;
    w_nextDwell  = r_dwell;
    w_nextSwitch = 1'b0;
    w_load       = 1'b0;
    w_blank      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (|req) begin
          w_nextState  = S_OWN;
          w_nextOwner  = w_idleWinner;
          w_nextDwell  = '0;
          w_nextSwitch = 1'b1;
          w_load       = 1'b1;
        end else begin
          w_blank = 1'b1;
        end
      end
      S_OWN: begin
        if (w_req0Rise && (r_owner != 2'd0)) begin
          w_nextOwner  = 2'd0;
          w_nextDwell  = '0;
          w_nextSwitch = 1'b1;
          w_load       = 1'b1;
        end else if (w_holdDone && w_othersReq) begin
          w_nextOwner  = w_rotWinner;
          w_nextRrLast = r_owner;
          w_nextDwell  = '0;
          w_nextSwitch = 1'b1;
          w_load       = 1'b1;
        end else if (w_holdDone && req[r_owner]) begin
          w_load = 1'b1;
        end else if (w_holdDone) begin
          w_nextState  = S_IDLE;
          w_nextRrLast = r_owner;
          w_blank      = 1'b1;
        end else begin
          w_nextDwell = r_dwell + DW'(1);
          w_load      = req[r_owner];
        end
      end
      default: begin
        w_nextState = S_IDLE;
        w_blank     = 1'b1;
      end
    endcase
  end

  // Arbitration state, dwell counter, alert edge detector and grant outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= S_IDLE;
      r_owner  <= 2'd0;
      r_rrLast <= 2'd2;
      r_dwell  <= '0;
      r_req0d  <= 1'b0;
      r_grant  <= 3'b000;
      r_switch <= 1'b0;
    end else begin
      r_state  <= w_nextState;
      r_owner  <= w_nextOwner;
      r_rrLast <= w_nextRrLast;
      r_dwell  <= w_nextDwell;
      r_req0d  <= req[0];
      r_grant  <= (w_nextState == S_OWN) ? toOneHot(w_nextOwner) : 3'b000;
      r_switch <= w_nextSwitch;
    end
  end

  // Digit data selection: blank, reload from the (next) owner, or freeze.
  always_comb begin
    w_nextHexs    = r_hexs;
    w_nextPoints  = r_points;
    w_nextLesData = r_lesData;
    if (w_blank) begin
      w_nextHexs    = 16'h0000;
      w_nextPoints  = 4'hF;
      w_nextLesData = 4'hF;
    end else if (w_load) begin
      w_nextHexs    = hexs_in[{w_nextOwner, 4'b0000} +: 16];
      w_nextPoints  = points_in[{w_nextOwner, 2'b00} +: 4];
      w_nextLesData = LEs_in[{w_nextOwner, 2'b00} +: 4];
    end
  end

  // Registered digit data toward the display driver.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_hexs    <= 16'h0000;
      r_points  <= 4'hF;
      r_lesData <= 4'hF;
    end else begin
      r_hexs    <= w_nextHexs;
      r_points  <= w_nextPoints;
      r_lesData <= w_nextLesData;
    end
  end

`ifdef DISPLAY_ARBITER_BLINK_EN
  logic [BLINK_BIT:0] r_blinkCnt;
  logic [3:0]         r_lesOut;
  logic               w_blinkOff;

  assign w_blinkOff = (w_nextState == S_OWN) && blink[w_nextOwner] && r_blinkCnt[BLINK_BIT];

  // Free-running blink phase; blanks all digits of a blinking owner in the on phase.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_blinkCnt <= '0;
      r_lesOut   <= 4'hF;
    end else begin
      r_blinkCnt <= r_blinkCnt + (BLINK_BIT + 1)'(1);
      r_lesOut   <= w_blinkOff ? 4'hF : w_nextLesData;
    end
  end

  assign LEs = r_lesOut;
`else
  logic [BLINK_BIT:0] w_unusedBlink;
  assign w_unusedBlink = (BLINK_BIT + 1)'(^blink);
  assign LEs = r_lesData;
`endif

  assign hexs         = r_hexs;
  assign points       = r_points;
  assign grant        = r_grant;
  assign busy         = |r_grant;
  assign switch_pulse = r_switch;

endmodule
